lut_function_unit: RTL

Parametrised, reprogrammable N-input Boolean function unit. A truth table of 2^N_IN bits, serially loadable, replaces hand-built gate networks. The unit gives a registered evaluation F for input vector x. It also runs a sequential sweep over every input combination, reporting the minterm count and the lowest true minterm. It serves as the standard combinational-function exercise block, and its sweep provides self-check for the digital-design labs.

---
 rtl/fn_unit_pkg.sv | 18 +
 rtl/tt_shift_reg.sv | 35 +++
 rtl/lut_function_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fn_unit_pkg.sv
// Shared definitions for the LUT function unit: FSM encoding, table width, legal N_IN range.
package fn_unit_pkg;

  localparam int N_IN_MIN = 2;
  localparam int N_IN_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Number of truth-table entries for an n-input function.
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_shift_reg.sv
// Truth-table store: serial shift-in load, reset to a default table, two index read ports
// (one for evaluation, one for the sweep engine).
module tt_shift_reg
  import fn_unit_pkg::*;
#(
  parameter int                        N_IN       = 4,
  parameter logic [tt_width(N_IN)-1:0] DEFAULT_TT = 16'h0DD0
) (
  input  logic            clock,
  input  logic            reset_b,
  input  logic            i_shift_en,
  input  logic            i_bit,
  input  logic [N_IN-1:0] i_eval_idx,
  input  logic [N_IN-1:0] i_sweep_idx,
  output logic            o_eval_bit,
  output logic            o_sweep_bit
);

  localparam int TT_W = tt_width(N_IN);

  logic [TT_W-1:0] r_tt;

  // Shift a new bit in at index 0; the oldest bit ends up at the top after TT_W loads.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_tt <= DEFAULT_TT;
    end else if (i_shift_en) begin
      r_tt <= {r_tt[TT_W-2:0], i_bit};
    end
  end

  assign o_eval_bit  = r_tt[i_eval_idx];
  assign o_sweep_bit = r_tt[i_sweep_idx];

endmodule

// File: rtl/lut_function_unit.sv
// Reprogrammable N-input Boolean function: registered evaluation plus a sweep that counts
// minterms and finds the lowest true index.
//
// state | meaning
// IDLE  | evaluating; accepts start or serial table loads
// SWEEP | walking idx over every table entry, table frozen
// DONE  | publishing count/first_idx/none, raising the done pulse
module lut_function_unit
  import fn_unit_pkg::*;
#(
  parameter int                        N_IN       = 4,
  parameter logic [tt_width(N_IN)-1:0] DEFAULT_TT = 16'h0DD0
) (
  input  logic            clock,
  input  logic            reset_b,
  input  logic            load_en,
  input  logic            load_bit,
  input  logic [N_IN-1:0] x,
  input  logic            start,
  output logic            F,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   count,
  output logic [N_IN-1:0] first_idx,
  output logic            none
);

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("lut_function_unit: N_IN outside the supported range");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N_IN-1:0] r_idx;
  logic [N_IN-1:0] r_fidx;
  logic [N_IN:0]   r_acc;
  logic            r_found;
  logic            r_done;
  logic            r_f;
  logic [N_IN:0]   r_count;
  logic [N_IN-1:0] r_first_idx;
  logic            r_none;

  logic w_idle;
  logic w_start_ok;
  logic w_load_ok;
  logic w_last;
  logic w_clear;
  logic w_step;
  logic w_finish;
  logic w_eval_bit;
  logic w_sweep_bit;

  // Start is accepted as soon as the FSM is back in IDLE, even while the trailing
  // done cycle still holds busy high; start has priority over a simultaneous load.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_start_ok = w_idle && start;
  assign w_load_ok  = w_idle && load_en && !start;
  assign w_last     = &r_idx;

  tt_shift_reg #(
    .N_IN       (N_IN),
    .DEFAULT_TT (DEFAULT_TT)
  ) u_tt (
    .clock       (clock),
    .reset_b     (reset_b),
    .i_shift_en  (w_load_ok),
    .i_bit       (load_bit),
    .i_eval_idx  (x),
    .i_sweep_idx (r_idx),
    .o_eval_bit  (w_eval_bit),
    .o_sweep_bit (w_sweep_bit)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-state datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_finish    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sweep engine: index walk, minterm accumulator and first-true capture.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_idx   <= '0;
      r_acc   <= '0;
      r_found <= 1'b0;
      r_fidx  <= '0;
    end else if (w_clear) begin
      r_idx   <= '0;
      r_acc   <= '0;
      r_found <= 1'b0;
      r_fidx  <= '0;
    end else if (w_step) begin
      if (w_sweep_bit) begin
        r_acc <= r_acc + 1'b1;
        if (!r_found) begin
          r_fidx  <= r_idx;
          r_found <= 1'b1;
        end
      end
      if (!w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Result registers hold until the next completed sweep; done is a one-cycle pulse.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_done      <= 1'b0;
      r_count     <= '0;
      r_first_idx <= '0;
      r_none      <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_count     <= r_acc;
        r_first_idx <= r_found ? r_fidx : '0;
        r_none      <= !r_found;
      end
    end
  end

  // Registered evaluation, running in every state.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_f <= 1'b0;
    end else begin
      r_f <= w_eval_bit;
    end
  end

  assign F         = r_f;
  assign busy      = (r_state != ST_IDLE) || r_done;
  assign done      = r_done;
  assign count     = r_count;
  assign first_idx = r_first_idx;
  assign none      = r_none;

endmodule
